// File: rtl/hovalaag_pkg.sv
// Shared defaults and read-FSM encoding for the OUT1 capture block.
package hovalaag_pkg;

    localparam int DATA_W_DEF     = 12;
    localparam int DEPTH_LOG2_DEF = 11;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_RAM  = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture storage: one write port, one registered read-first read port.
// Contents are intentionally not reset.
module capture_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Separate process sampling the pre-edge array gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/output_capture.sv
// Captures qualified CPU OUT1 writes into a RAM and serves host reads with fixed 2-cycle latency.
// Captures beyond full are dropped and flagged sticky; host requests are ignored while busy.
module output_capture
    import hovalaag_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int AF_MARGIN  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_en,
    input  logic [DATA_W-1:0]     cap_data,
    input  logic                  host_clear,
    input  logic                  host_rd_req,
    input  logic [DEPTH_LOG2-1:0] host_rd_addr,
    output logic                  host_rd_busy,
    output logic                  host_rd_valid,
    output logic [DATA_W-1:0]     host_rd_data,
    output logic                  host_rd_oob,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [DATA_W-1:0]     last_value
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_AF   = (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);

    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_W-1:0]     last_q, last_d;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;

    rd_state_e             state_q, state_d;
    logic [DEPTH_LOG2-1:0] rd_addr_q, rd_addr_d;
    logic                  pend_oob_q, pend_oob_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_oob_q, rd_oob_d;
    logic [DATA_W-1:0]     ram_rdata;

    assign full        = (count_q == CNT_FULL);
    assign almost_full = (count_q >= CNT_AF);

    // Clear rewinds the write pointer first, so a coincident capture lands at index 0.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        last_d     = last_q;
        wr_en      = 1'b0;
        wr_addr    = count_q[DEPTH_LOG2-1:0];
        if (host_clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
            wr_addr    = '0;
        end
        if (cap_en) begin
            if (host_clear || !full) begin
                wr_en   = 1'b1;
                count_d = count_d + 1'b1;
                last_d  = cap_data;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        pend_oob_d = pend_oob_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_oob_d   = rd_oob_q;
        case (state_q)
            RD_IDLE: begin
                if (host_rd_req) begin
                    state_d    = RD_RAM;
                    rd_addr_d  = host_rd_addr;
                    pend_oob_d = ({1'b0, host_rd_addr} >= count_q);
                end
            end
            RD_RAM: begin
                state_d = RD_RESP;
            end
            RD_RESP: begin
                state_d    = RD_IDLE;
                rd_valid_d = 1'b1;
                rd_data_d  = pend_oob_q ? '0 : ram_rdata;
                rd_oob_d   = pend_oob_q;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RD_IDLE;
            rd_addr_q  <= '0;
            pend_oob_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_oob_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            pend_oob_q <= pend_oob_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_oob_q   <= rd_oob_d;
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (cap_data),
        .rd_en_i   (state_q == RD_RAM),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (ram_rdata)
    );

    assign host_rd_busy  = (state_q != RD_IDLE);
    assign host_rd_valid = rd_valid_q;
    assign host_rd_data  = rd_data_q;
    assign host_rd_oob   = rd_oob_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign last_value    = last_q;

endmodule

// File: doc/output_capture.md
OUTPUT_CAPTURE -- requirements
Module: output_capture

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 12, the width of a captured OUT value.
REQ-002 The block SHALL provide parameter DEPTH_LOG2, default 11, giving a capture depth of 2048 entries.
REQ-003 The block SHALL provide parameter AF_MARGIN, default 16, the almost_full threshold distance from full.
REQ-004 clk  in  1  system clock; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cap_en  in  1  one-cycle strobe: qualified CPU OUT1 write (OUT_valid, OUT_select=0, advance qualifier).
REQ-007 cap_data  in  DATA_W  OUT value sampled when cap_en=1.
REQ-008 host_clear  in  1  one-cycle strobe: discard the capture buffer.
REQ-009 host_rd_req  in  1  one-cycle host read request.
REQ-010 host_rd_addr  in  DEPTH_LOG2  capture index to read, sampled with host_rd_req.
REQ-011 host_rd_busy  out  1  read in progress; requests are ignored while high.
REQ-012 host_rd_valid  out  1  one-cycle pulse marking host_rd_data valid.
REQ-013 host_rd_data  out  DATA_W  read result, held until the next valid pulse.
REQ-014 host_rd_oob  out  1  qualifies host_rd_valid: the index was >= count at acceptance.
REQ-015 count  out  DEPTH_LOG2+1  number of stored entries, 0..2048.
REQ-016 full  out  1  high when count == 2^DEPTH_LOG2.
REQ-017 almost_full  out  1  high when count >= 2^DEPTH_LOG2 - AF_MARGIN; the top level uses it to pause the CPU.
REQ-018 overflow  out  1  sticky: a capture was dropped because the buffer was full.
REQ-019 last_value  out  DATA_W  most recently stored value, for the seven-segment display.

Function
REQ-020 On cap_en=1 with full=0, cap_data SHALL be written at index count, and count SHALL increment on the same edge.
REQ-021 On cap_en=1 with full=1, the write SHALL be suppressed, count SHALL hold, and overflow SHALL set on that edge.
REQ-022 last_value SHALL update to cap_data on every stored capture; dropped captures SHALL not update it.
REQ-023 On host_clear=1, count SHALL become 0 and overflow SHALL become 0; last_value SHALL hold.
REQ-024 When host_clear=1 and cap_en=1 in the same cycle, cap_data SHALL be written at index 0, count SHALL become 1, overflow SHALL become 0, and last_value SHALL update.
REQ-025 The read FSM SHALL have three states:
- IDLE -> RAM on host_rd_req=1, latching the address and oob = (addr >= count as of that cycle);
- RAM -> RESP unconditionally;
- RESP -> IDLE unconditionally.
REQ-026 host_rd_busy SHALL be high in RAM and RESP; host_rd_req SHALL be ignored outside IDLE.
REQ-027 In RESP, host_rd_valid SHALL be 1 and host_rd_data SHALL load the RAM output, or 0 if oob.
REQ-028 host_rd_oob SHALL load with host_rd_data and hold with it.
REQ-029 Read latency SHALL be fixed: host_rd_valid asserts exactly 2 cycles after the accepting edge.
REQ-030 A read SHALL never disturb capture; capture and read ports operate concurrently.
REQ-031 A read of an index written in the acceptance cycle SHALL be flagged oob; a read of an index written in the RAM cycle SHALL return the old contents (read-first).
REQ-032 host_clear during a read SHALL not abort it; the returned data and oob SHALL reflect the state at acceptance.

Reset
REQ-033 While reset=1, the following SHALL be 0 and the read FSM SHALL be IDLE: count, full, almost_full, overflow, last_value, host_rd_busy, host_rd_valid, host_rd_data, host_rd_oob.
REQ-034 Reset SHALL take priority over cap_en and host_clear.
REQ-035 Reset during a read SHALL abort it with no host_rd_valid pulse.
REQ-036 RAM contents SHALL not be reset.

Structure
REQ-037 DATA_W and DEPTH_LOG2 defaults and the read FSM state encoding SHALL live in shared package hovalaag_pkg.
REQ-038 Storage SHALL be one sub-module, capture_ram: simple dual-port, 1 write port, 1 registered read port, read-first, block-RAM inferable.

Verification
REQ-039 Reset, then 3 captures 0x123, 0x456, 0x789 -> count=3, last_value=0x789; reads of index 1 return 0x456, oob=0, valid exactly 2 cycles after the request.
REQ-040 2048 captures of value=index -> full=1; almost_full first rises at count=2032; the 2049th capture -> count=2048, overflow=1, last_value=0x7FF.
REQ-041 host_clear and cap_en(0xABC) in the same cycle with count=5 -> count=1, overflow=0, index 0 reads 0xABC.
REQ-042 count=2, read index 2 -> host_rd_data=0, oob=1; a request while busy -> ignored, exactly one valid pulse.
REQ-043 Reset asserted in the RAM state -> no host_rd_valid pulse; all outputs 0 the cycle after reset.
